// File: rtl/transformer_pkg.sv
// Shared transformer-stage types: Q16.16 vertices, triangles and the 6-plane outcode.
// Used by triangle_outcode_culler (optional back-face culling via CULLER_BACKFACE_EN).
package transformer_pkg;

  typedef struct packed {
    logic signed [31:0] x;
    logic signed [31:0] y;
    logic signed [31:0] z;
  } pos_t;

  typedef struct packed {
    pos_t pos;
  } vertex_t;

  typedef struct packed {
    vertex_t v0;
    vertex_t v1;
    vertex_t v2;
  } triangle_t;

  typedef struct packed {
    logic z_far;
    logic z_near;
    logic y_max;
    logic y_min;
    logic x_max;
    logic x_min;
  } outcode_t;

  localparam int OC_XMIN = 0;
  localparam int OC_XMAX = 1;
  localparam int OC_YMIN = 2;
  localparam int OC_YMAX = 3;
  localparam int OC_NEAR = 4;
  localparam int OC_FAR  = 5;

  // Points exactly on a bound count as inside.
  function automatic outcode_t compute_outcode(
    input vertex_t            v,
    input logic signed [31:0] xmin,
    input logic signed [31:0] xmax,
    input logic signed [31:0] ymin,
    input logic signed [31:0] ymax,
    input logic signed [31:0] near,
    input logic signed [31:0] far
  );
    outcode_t oc;
    oc.x_min  = $signed(v.pos.x) < xmin;
    oc.x_max  = $signed(v.pos.x) > xmax;
    oc.y_min  = $signed(v.pos.y) < ymin;
    oc.y_max  = $signed(v.pos.y) > ymax;
    oc.z_near = $signed(v.pos.z) < near;
    oc.z_far  = $signed(v.pos.z) > far;
    return oc;
  endfunction

endpackage

// File: rtl/triangle_outcode_culler_vertex_outcode.sv
// Combinational 6-plane outcode for a single vertex.
module vertex_outcode
  import transformer_pkg::*;
(
  input  vertex_t            vertex,
  input  logic signed [31:0] xmin,
  input  logic signed [31:0] xmax,
  input  logic signed [31:0] ymin,
  input  logic signed [31:0] ymax,
  input  logic signed [31:0] near,
  input  logic signed [31:0] far,
  output outcode_t           outcode
);

  assign outcode = compute_outcode(vertex, xmin, xmax, ymin, ymax, near, far);

endmodule

// File: rtl/triangle_outcode_culler.sv
// Two-stage frustum culler: outcodes in stage 1, keep decision in stage 2, saturating stats.
// Back-face (A <= 0) culling is compiled in when CULLER_BACKFACE_EN is defined.
module triangle_outcode_culler
  import transformer_pkg::*;
#(
  parameter int WIDTH      = 320,
  parameter int HEIGHT     = 240,
  parameter int NEAR_PLANE = 1,
  parameter int FAR_PLANE  = 1000,
  parameter int GUARD_BAND = 0,
  parameter int CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  triangle_t        triangle,
  input  logic             in_valid,
  output logic             in_ready,
  output triangle_t        out_triangle,
  output logic             out_valid,
  input  logic             out_ready,
  input  logic             stats_clear,
  output logic [CNT_W-1:0] passed_count,
  output logic [CNT_W-1:0] culled_count,
  output logic             busy
);

  localparam logic signed [31:0] XMIN = -(GUARD_BAND * 65536);
  localparam logic signed [31:0] XMAX = (WIDTH + GUARD_BAND) * 65536;
  localparam logic signed [31:0] YMIN = -(GUARD_BAND * 65536);
  localparam logic signed [31:0] YMAX = (HEIGHT + GUARD_BAND) * 65536;
  localparam logic signed [31:0] ZNEAR = NEAR_PLANE * 65536;
  localparam logic signed [31:0] ZFAR  = FAR_PLANE * 65536;

  outcode_t  oc0, oc1, oc2;
  outcode_t  s1_oc0, s1_oc1, s1_oc2, oc_all;
  triangle_t s1_tri, s2_tri;
  logic      s1_valid, s2_valid, s2_keep, s1_keep, near_any;
  logic      s1_accept, s2_accept, pass_evt, cull_evt;

  vertex_outcode u_oc0 (
    .vertex(triangle.v0), .xmin(XMIN), .xmax(XMAX), .ymin(YMIN), .ymax(YMAX),
    .near(ZNEAR), .far(ZFAR), .outcode(oc0)
  );
  vertex_outcode u_oc1 (
    .vertex(triangle.v1), .xmin(XMIN), .xmax(XMAX), .ymin(YMIN), .ymax(YMAX),
    .near(ZNEAR), .far(ZFAR), .outcode(oc1)
  );
  vertex_outcode u_oc2 (
    .vertex(triangle.v2), .xmin(XMIN), .xmax(XMAX), .ymin(YMIN), .ymax(YMAX),
    .near(ZNEAR), .far(ZFAR), .outcode(oc2)
  );

  // A culled stage-2 entry drains without waiting for out_ready.
  assign out_valid    = s2_valid && s2_keep;
  assign s2_accept    = !s2_valid || !s2_keep || out_ready;
  assign s1_accept    = !s1_valid || s2_accept;
  assign in_ready     = s1_accept;
  assign busy         = s1_valid || s2_valid;
  assign out_triangle = s2_tri;
  assign pass_evt     = out_valid && out_ready;
  assign cull_evt     = s2_valid && !s2_keep;

  assign oc_all   = s1_oc0 & s1_oc1 & s1_oc2;
  assign near_any = s1_oc0[OC_NEAR] || s1_oc1[OC_NEAR] || s1_oc2[OC_NEAR];

`ifdef CULLER_BACKFACE_EN
  logic signed [32:0] dx1, dy1, dx2, dy2;
  logic signed [65:0] prod_a, prod_b;
  logic signed [66:0] area;
  logic               s1_front;

  always_comb begin
    dx1    = 33'(triangle.v1.pos.x) - 33'(triangle.v0.pos.x);
    dy1    = 33'(triangle.v1.pos.y) - 33'(triangle.v0.pos.y);
    dx2    = 33'(triangle.v2.pos.x) - 33'(triangle.v0.pos.x);
    dy2    = 33'(triangle.v2.pos.y) - 33'(triangle.v0.pos.y);
    prod_a = 66'(dx1) * 66'(dy2);
    prod_b = 66'(dx2) * 66'(dy1);
    area   = 67'(prod_a) - 67'(prod_b);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_front <= 1'b0;
    end else if (s1_accept && in_valid) begin
      s1_front <= area > 67'sd0;
    end
  end

  assign s1_keep = (oc_all == '0) && !near_any && s1_front;
`else
  assign s1_keep = (oc_all == '0) && !near_any;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_tri   <= '0;
      s1_oc0   <= '0;
      s1_oc1   <= '0;
      s1_oc2   <= '0;
    end else if (s1_accept) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_tri <= triangle;
        s1_oc0 <= oc0;
        s1_oc1 <= oc1;
        s1_oc2 <= oc2;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid <= 1'b0;
      s2_keep  <= 1'b0;
      s2_tri   <= '0;
    end else if (s2_accept) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_tri  <= s1_tri;
        s2_keep <= s1_keep;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      passed_count <= '0;
    end else if (stats_clear) begin
      passed_count <= '0;
    end else if (pass_evt && (passed_count != '1)) begin
      passed_count <= passed_count + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      culled_count <= '0;
    end else if (stats_clear) begin
      culled_count <= '0;
    end else if (cull_evt && (culled_count != '1)) begin
      culled_count <= culled_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_triangle_outcode_culler.sv
// Bench for triangle_outcode_culler: directed steps plus randomized traffic against a plane-count model.
`timescale 1ns/1ps
module tb_triangle_outcode_culler;
  import transformer_pkg::*;

  localparam int CNT_W    = 8;
  localparam int GB_CNT_W = 4;

  logic                clk = 1'b0;
  logic                rst;
  triangle_t           triangle;
  logic                in_valid, gb_in_valid, out_ready, stats_clear;
  logic                in_ready, out_valid, busy;
  triangle_t           out_triangle;
  logic [CNT_W-1:0]    passed_count, culled_count;
  logic                gb_in_ready, gb_out_valid, gb_busy;
  triangle_t           gb_out_triangle;
  logic [GB_CNT_W-1:0] gb_passed_count, gb_culled_count;

  always #5 clk = ~clk;

  triangle_outcode_culler #(.GUARD_BAND(0), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .triangle(triangle), .in_valid(in_valid), .in_ready(in_ready),
    .out_triangle(out_triangle), .out_valid(out_valid), .out_ready(out_ready),
    .stats_clear(stats_clear), .passed_count(passed_count), .culled_count(culled_count),
    .busy(busy)
  );

  triangle_outcode_culler #(.GUARD_BAND(64), .CNT_W(GB_CNT_W)) dut_gb (
    .clk(clk), .rst(rst), .triangle(triangle), .in_valid(gb_in_valid), .in_ready(gb_in_ready),
    .out_triangle(gb_out_triangle), .out_valid(gb_out_valid), .out_ready(out_ready),
    .stats_clear(stats_clear), .passed_count(gb_passed_count), .culled_count(gb_culled_count),
    .busy(gb_busy)
  );

  int        total = 0;
  int        bad = 0;
  triangle_t exp_q[$];
  int        m_pass = 0;
  int        m_cull = 0;
  int        gb_seen = 0;
  bit        last_acc, last_ov, stall_prev;
  triangle_t stall_tri;

  task automatic check(input string tag, input logic [287:0] obs, input logic [287:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic int sat(input int v, input int w);
    int lim = (1 << w) - 1;
    return (v > lim) ? lim : v;
  endfunction

  function automatic vertex_t vq(input int x, input int y, input int z);
    vertex_t v;
    v.pos.x = x;
    v.pos.y = y;
    v.pos.z = z;
    return v;
  endfunction

  function automatic triangle_t tri_px(input int x0, y0, x1, y1, x2, y2, input int z);
    triangle_t t;
    t.v0 = vq(x0 * 65536, y0 * 65536, z * 65536);
    t.v1 = vq(x1 * 65536, y1 * 65536, z * 65536);
    t.v2 = vq(x2 * 65536, y2 * 65536, z * 65536);
    return t;
  endfunction

  // Cull if any vertex is in front of the near plane, or all three lie beyond one plane.
  function automatic bit model_keep(input triangle_t t, input int gb);
    longint xs[3], ys[3], zs[3];
    longint lo, hix, hiy;
    int n_l, n_r, n_t, n_b, n_f;
    xs[0] = longint'($signed(t.v0.pos.x)); ys[0] = longint'($signed(t.v0.pos.y));
    zs[0] = longint'($signed(t.v0.pos.z));
    xs[1] = longint'($signed(t.v1.pos.x)); ys[1] = longint'($signed(t.v1.pos.y));
    zs[1] = longint'($signed(t.v1.pos.z));
    xs[2] = longint'($signed(t.v2.pos.x)); ys[2] = longint'($signed(t.v2.pos.y));
    zs[2] = longint'($signed(t.v2.pos.z));
    lo  = -longint'(gb) * 65536;
    hix = longint'(320 + gb) * 65536;
    hiy = longint'(240 + gb) * 65536;
    n_l = 0; n_r = 0; n_t = 0; n_b = 0; n_f = 0;
    for (int i = 0; i < 3; i++) begin
      if (zs[i] < 65536) return 1'b0;
      if (xs[i] < lo)  n_l++;
      if (xs[i] > hix) n_r++;
      if (ys[i] < lo)  n_t++;
      if (ys[i] > hiy) n_b++;
      if (zs[i] > longint'(1000) * 65536) n_f++;
    end
    if (n_l == 3 || n_r == 3 || n_t == 3 || n_b == 3 || n_f == 3) return 1'b0;
`ifdef CULLER_BACKFACE_EN
    if ((xs[1] - xs[0]) * (ys[2] - ys[0]) - (xs[2] - xs[0]) * (ys[1] - ys[0]) <= 0) return 1'b0;
`endif
    return 1'b1;
  endfunction

  function automatic triangle_t rand_tri();
    triangle_t t;
    int        xoff;
    xoff = ($urandom_range(0, 3) == 0) ? 530 * 65536 : 0;
    t.v0 = vq(int'($urandom_range(0, 720 * 65536)) - 200 * 65536 + xoff,
              int'($urandom_range(0, 640 * 65536)) - 200 * 65536,
              int'($urandom_range(0, 1100 * 65536)) - 50 * 65536);
    t.v1 = vq(int'($urandom_range(0, 720 * 65536)) - 200 * 65536 + xoff,
              int'($urandom_range(0, 640 * 65536)) - 200 * 65536,
              int'($urandom_range(0, 1100 * 65536)) - 50 * 65536);
    t.v2 = vq(int'($urandom_range(0, 720 * 65536)) - 200 * 65536 + xoff,
              int'($urandom_range(0, 640 * 65536)) - 200 * 65536,
              int'($urandom_range(0, 1100 * 65536)) - 50 * 65536);
    return t;
  endfunction

  // One clock: observe handshakes at the falling edge, then move to just past the rising edge.
  task automatic step();
    triangle_t e;
    @(negedge clk);
    last_acc = in_valid && in_ready;
    last_ov  = out_valid;
    if (stall_prev) begin
      check("stall_hold_valid", out_valid, 1'b1);
      check("stall_hold_data", out_triangle, stall_tri);
    end
    if (last_acc) begin
      if (model_keep(triangle, 0)) exp_q.push_back(triangle);
      else m_cull = sat(m_cull + 1, CNT_W);
    end
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("out_when_none_expected", out_valid, 1'b0);
      end else begin
        e = exp_q.pop_front();
        check("out_data", out_triangle, e);
        m_pass = sat(m_pass + 1, CNT_W);
      end
    end
    if (stats_clear) begin
      m_pass = 0;
      m_cull = 0;
    end
    if (gb_out_valid && out_ready) gb_seen++;
    stall_prev = out_valid && !out_ready;
    stall_tri  = out_triangle;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input triangle_t t);
    int n = 0;
    triangle = t;
    in_valid = 1'b1;
    do begin
      step();
      n++;
    end while (!last_acc && n < 100);
    in_valid = 1'b0;
    check("send_accept", last_acc, 1'b1);
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while ((exp_q.size() != 0 || busy) && n < 200) begin
      step();
      n++;
    end
    check({tag, "_drain_busy"}, busy, 1'b0);
    check({tag, "_drain_queue"}, exp_q.size(), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    triangle_t tA, tB, tC, tD, t;
    triangle_t stall_list[8];
    int        idx, sent, n;

    rst = 1'b1; triangle = '0; in_valid = 1'b0; gb_in_valid = 1'b0;
    out_ready = 1'b1; stats_clear = 1'b0; stall_prev = 1'b0; stall_tri = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_passed", passed_count, 0);
    check("rst_culled", culled_count, 0);
    check("rst_out_triangle", out_triangle, '0);
    check("rst_in_ready", in_ready, 1'b1);
    @(posedge clk); #1;

    // Basic pass-through and 2-cycle latency
    tA = tri_px(10, 10, 100, 10, 10, 100, 5);
    triangle = tA; in_valid = 1'b1;
    step();
    check("t1_accept", last_acc, 1'b1);
    in_valid = 1'b0;
    step();
    check("t1_valid_cycle1", last_ov, 1'b0);
    step();
    check("t1_valid_cycle2", last_ov, 1'b1);
    drain("t1");
    check("t1_passed", passed_count, 1);

    // Fully left of the viewport: culled without guard band, kept with 64 px guard band
    tB = tri_px(-50, 10, -50, 100, -50, 50, 5);
    gb_seen = 0;
    gb_in_valid = 1'b1;
    send(tB);
    gb_in_valid = 1'b0;
    drain("t2");
    step(); step();
    check("t2_culled", culled_count, 1);
    check("t2_passed", passed_count, 1);
    check("t2_gb_seen", gb_seen, 1);
    check("t2_gb_passed", gb_passed_count, 1);
    check("t2_gb_culled", gb_culled_count, 0);

    // Spanning both x sides is kept; a vertex at z=0.5 is near-culled
    tC = tri_px(-20, 10, 400, 50, 100, 200, 5);
    tD = tC;
    tD.v2.pos.z = 32'sh0000_8000;
    send(tC);
    send(tD);
    drain("t3");
    check("t3_passed", passed_count, 2);
    check("t3_culled", culled_count, 2);

    // Back-to-back under a 5-cycle output stall
    for (int i = 0; i < 8; i++)
      stall_list[i] = tri_px(10 + i, 20, 200, 30 + i, 50, 150, 7 + i);
    out_ready = 1'b0;
    idx = 0;
    for (int c = 0; c < 5; c++) begin
      triangle = stall_list[idx]; in_valid = 1'b1;
      step();
      if (last_acc) idx++;
    end
    check("t4_accepted_in_stall", idx, 2);
    check("t4_in_ready_low", in_ready, 1'b0);
    check("t4_out_valid_held", out_valid, 1'b1);
    out_ready = 1'b1;
    n = 0;
    while (idx < 8 && n < 100) begin
      triangle = stall_list[idx]; in_valid = 1'b1;
      step();
      if (last_acc) idx++;
      n++;
    end
    in_valid = 1'b0;
    check("t4_all_accepted", idx, 8);
    drain("t4");
    check("t4_passed", passed_count, 10);
    check("t4_passed_model", passed_count, m_pass);

    // Winding: CCW, CW and collinear
    send(tri_px(0, 0, 10, 0, 0, 10, 5));
    send(tri_px(0, 0, 0, 10, 10, 0, 5));
    send(tri_px(0, 0, 5, 5, 10, 10, 5));
    drain("t5");
    check("t5_passed", passed_count, m_pass);
    check("t5_culled", culled_count, m_cull);

    // Clear, then clear on the same cycle as a pass
    stats_clear = 1'b1;
    step();
    stats_clear = 1'b0;
    check("t6_clear_passed", passed_count, 0);
    check("t6_clear_culled", culled_count, 0);
    check("t6_clear_gb", gb_passed_count, 0);
    send(tA);
    step();
    stats_clear = 1'b1;
    step();
    stats_clear = 1'b0;
    check("t6_pass_cycle", last_ov, 1'b1);
    check("t6_clear_wins", passed_count, 0);
    drain("t6");

    // Saturation of a 4-bit counter
    gb_seen = 0;
    triangle = tA;
    gb_in_valid = 1'b1;
    repeat (20) step();
    gb_in_valid = 1'b0;
    repeat (4) step();
    check("t7_gb_seen", gb_seen, 20);
    check("t7_gb_saturated", gb_passed_count, 15);
    check("t7_gb_idle", gb_busy, 1'b0);

    // Randomized traffic with random back-pressure
    stats_clear = 1'b1;
    step();
    stats_clear = 1'b0;
    sent = 0;
    in_valid = 1'b0;
    for (int c = 0; c < 5000 && sent < 300; c++) begin
      if (!in_valid && $urandom_range(0, 9) < 7) begin
        triangle = rand_tri();
        in_valid = 1'b1;
      end
      out_ready = ($urandom_range(0, 9) < 6);
      step();
      if (last_acc) begin
        sent++;
        in_valid = 1'b0;
        if ($urandom_range(0, 9) < 7) begin
          triangle = rand_tri();
          in_valid = 1'b1;
        end
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    check("rand_sent", sent, 300);
    drain("rand");
    check("rand_passed", passed_count, m_pass);
    check("rand_culled", culled_count, m_cull);

    // Reset mid-stream discards everything in flight
    out_ready = 1'b0;
    for (int c = 0; c < 4; c++) begin
      triangle = stall_list[c]; in_valid = 1'b1;
      step();
    end
    in_valid = 1'b0;
    check("t8_busy_before", busy, 1'b1);
    rst = 1'b1;
    #1;
    check("t8_busy_rst", busy, 1'b0);
    check("t8_valid_rst", out_valid, 1'b0);
    check("t8_passed_rst", passed_count, 0);
    check("t8_culled_rst", culled_count, 0);
    exp_q.delete();
    m_pass = 0; m_cull = 0;
    stall_prev = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b1;
    repeat (6) step();
    check("t8_no_output_passed", passed_count, 0);
    check("t8_no_output_culled", culled_count, 0);
    check("t8_idle", busy, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/triangle_outcode_culler.md
# triangle_outcode_culler

Second-generation frustum culler for the transformer stage. It takes screen-space triangles (Q16.16 x/y/z) on a valid/ready stream and computes a 6-plane outcode per vertex with a configurable guard band. It drops triangles that are trivially outside, or that touch the near plane, since there is no clipper downstream. Survivors go on to the rasteriser setup.

It is a two-stage registered pipeline with saturating pass/cull statistics counters and optional back-face culling.

## Interface
- WIDTH, 320: viewport width in pixels.
- HEIGHT, 240: viewport height in pixels.
- NEAR_PLANE, 1: near z, integer; compared as NEAR_PLANE<<16.
- FAR_PLANE, 1000: far z, integer; compared as FAR_PLANE<<16.
- GUARD_BAND, 0: guard band in pixels, ≥0, added on all four x/y sides.
- CNT_W, 32: statistics counter width.
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-high.
- triangle  in  triangle_t  input triangle (v0,v1,v2; pos.x/y/z signed Q16.16).
- in_valid  in  1  input valid.
- in_ready  out  1  input ready.
- out_triangle  out  triangle_t  surviving triangle; bit-exact copy of the input.
- out_valid  out  1  output valid.
- out_ready  in  1  downstream ready.
- stats_clear  in  1  synchronous clear of both counters.
- passed_count  out  CNT_W  triangles emitted; saturating.
- culled_count  out  CNT_W  triangles dropped; saturating.
- busy  out  1  high while either stage holds a triangle.

## Operation
- Outcode bit order per vertex, [5:0] = {z>far, z<near, y>Hmax, y<Ymin, x>Xmax, x<Xmin}.
  - Xmin = Ymin = −GUARD_BAND<<16.
  - Xmax = (WIDTH+GUARD_BAND)<<16; Ymax = (HEIGHT+GUARD_BAND)<<16.
  - All comparisons are signed 32-bit.
  - Values exactly on a bound are inside.
- Stage 1 registers the triangle and the three outcodes.
- Stage 2 registers the triangle plus a keep flag.
  - keep = ((oc0 & oc1 & oc2) == 0) && no vertex has the z<near bit set.
  - With back-face culling compiled in, keep additionally requires area > 0 (see Configuration).
- out_valid = s2_valid && s2_keep.
- A culled entry in stage 2 vacates in one cycle regardless of out_ready.
- Stage 2 accepts when it is empty, when it holds a culled entry, or when (out_valid && out_ready).
- Stage 1 accepts when it is empty or when it is moving into stage 2.
- in_ready = stage-1 accept condition; it depends combinationally on out_ready.
- Counters:
  - passed_count increments on an out_valid&&out_ready handshake.
  - culled_count increments on the cycle a culled entry leaves stage 2.
  - Both hold at 2^CNT_W−1.
  - stats_clear has priority over an increment in the same cycle.
- Reset:
  - Both valid flags, both counters and all data registers go to 0.
  - A reset mid-stream discards in-flight triangles with no output and no count.

## Timing
- Reset values: out_valid=0, busy=0, passed_count=0, culled_count=0, out_triangle=0. in_ready=1 after reset.
- Latency: an accepted triangle reaches out_valid 2 cycles after its input handshake if not stalled.
- Throughput is 1 triangle/cycle when out_ready=1 or when triangles are culled.
- Under stall (out_ready=0 with a kept triangle in stage 2), both stages fill. in_ready drops the cycle stage 1 is full and cannot advance.
- out_triangle is stable while out_valid && !out_ready.
- No combinational path from in_valid to out_valid.

## Configuration
- CULLER_BACKFACE_EN defined:
  - Stage 1 also computes signed area A = (x1−x0)(y2−y0) − (x2−x0)(y1−y0).
  - Operands are 33-bit differences, products are 66-bit signed, and A is kept at 67 bits.
  - Triangles with A ≤ 0 (clockwise or degenerate) are culled and counted in culled_count.
- Not defined: no area logic and no winding test. Latency is unchanged.

## Structure
- transformer_pkg gains:
  - outcode_t (6-bit packed struct, field order as above);
  - the OC_* bit-index constants;
  - function compute_outcode(vertex_t, xmin, xmax, ymin, ymax, near, far).
- Sub-module vertex_outcode, purely combinational, is instantiated three times in stage 1.
- The area computation stays inline and is guarded by the macro.

## Test plan
- One triangle (10,10,5),(100,10,5),(10,100,5), out_ready=1 → out_valid 2 cycles after handshake, identical data, passed_count=1.
- All three vertices at x=−50.0, GUARD_BAND=0 → no output, culled_count=1. With GUARD_BAND=64 → emitted.
- Vertices spanning x<0 and x>320 but all y in range (outcodes share no bit) → emitted. Any vertex at z=0.5 → culled as near.
- 8 back-to-back triangles with out_ready=0 for 5 cycles → in_ready low after 2 accepted. All 8 emitted in order with no duplicates once out_ready=1.
- With CULLER_BACKFACE_EN: CCW (0,0),(10,0),(0,10) kept; the same vertices with v1/v2 swapped culled; collinear culled.
- Counters forced near saturation with CNT_W=4: 20 passes → passed_count=15. stats_clear with a simultaneous pass → 0. Reset mid-stream → busy=0 and no output.
